// File: rtl/mips_pkg.sv
// Shared types for the MIPS hazard logic: shadow-stage record, bubble constant
// and the operand match helper used against each shadow stage.
package mips_pkg;

  localparam int REG_W = 5;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             reg_write;
    logic             mem_read;
  } hz_stage_t;

  localparam hz_stage_t HZ_BUBBLE = '{
    valid:     1'b0,
    dest:      {REG_W{1'b0}},
    reg_write: 1'b0,
    mem_read:  1'b0
  };

  // $0 is hard-wired, so a stage writing it can never create a dependency.
  function automatic logic operand_match(
    input logic             uses,
    input logic [REG_W-1:0] r,
    input hz_stage_t        st
  );
    return uses && (r != {REG_W{1'b0}}) && st.valid && (st.dest == r);
  endfunction

endpackage

// File: rtl/hazard_track_reg.sv
// One shadow pipeline stage: loads the incoming record or takes a bubble.
module hazard_track_reg
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load,
  input  hz_stage_t d,
  output hz_stage_t q
);

  // Stage register; a bubble is inserted whenever load is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= HZ_BUBBLE;
    end else if (load) begin
      q <= d;
    end else begin
      q <= HZ_BUBBLE;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use / branch-operand hazard controller with private EX and MEM shadow
// stages, bubble/hold/flush outputs and saturating stall and flush counters.
module hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic             idBranch,
  input  logic             idTaken,
  input  logic             idRegWrite,
  input  logic             idMemRead,
  input  logic [REG_W-1:0] idDest,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             ifidFlush,
  output logic             nopOut,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  import mips_pkg::*;

  hz_stage_t id_stage_s;
  hz_stage_t ex_stage_r;
  hz_stage_t mem_stage_r;

  logic ex_rs_s, ex_rt_s, mem_rs_s, mem_rt_s;
  logic load_use_s, branch_dep_s, stall_s, flush_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  assign id_stage_s = '{
    valid:     1'b1,
    dest:      idDest,
    reg_write: idRegWrite,
    mem_read:  idMemRead
  };

  hazard_track_reg u_ex (
    .clk  (clk),
    .rst  (rst),
    .load (~stall_s),
    .d    (id_stage_s),
    .q    (ex_stage_r)
  );

  hazard_track_reg u_mem (
    .clk  (clk),
    .rst  (rst),
    .load (1'b1),
    .d    (ex_stage_r),
    .q    (mem_stage_r)
  );

  assign ex_rs_s  = operand_match(idUsesRs, idRs, ex_stage_r);
  assign ex_rt_s  = operand_match(idUsesRt, idRt, ex_stage_r);
  assign mem_rs_s = operand_match(idUsesRs, idRs, mem_stage_r);
  assign mem_rt_s = operand_match(idUsesRt, idRt, mem_stage_r);

  // Branches resolve in ID, so they also wait on an ALU result still in EX and
  // on a load still in MEM; ordinary consumers only wait on a load in EX.
  assign load_use_s   = ex_stage_r.mem_read && (ex_rs_s || ex_rt_s);
  assign branch_dep_s = idBranch &&
                        ((ex_stage_r.reg_write && (ex_rs_s || ex_rt_s)) ||
                         (mem_stage_r.mem_read && (mem_rs_s || mem_rt_s)));
  assign stall_s      = load_use_s || branch_dep_s;
  assign flush_s      = idTaken && !stall_s;

  // While stalled the branch outcome is not yet trustworthy, so no flush.
  assign pcWrite   = !rst && !stall_s;
  assign ifidWrite = !rst && !stall_s;
  assign nopOut    = rst || stall_s;
  assign ifidFlush = !rst && flush_s;

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stallCnt = stall_cnt_r;
  assign flushCnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// instruction streams checked against an instruction-history reference model.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] idRs, idRt, idDest;
  logic       idUsesRs, idUsesRt, idBranch, idTaken, idRegWrite, idMemRead;
  logic       pcWrite, ifidWrite, ifidFlush, nopOut;
  logic [15:0] stallCnt, flushCnt;
  logic       s_pcWrite, s_ifidWrite, s_ifidFlush, s_nopOut;
  logic [3:0] s_stallCnt, s_flushCnt;

  int checks = 0;
  int errors = 0;

  // Instructions issued one and two cycles ago (older slot = MEM).
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
  } ent_t;

  ent_t        m_ex, m_mem;
  logic [15:0] m_sc, m_fc;
  logic [3:0]  m_sc4, m_fc4;

  always #5 clk = ~clk;

  hazard_unit u_dut (
    .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs),
    .idUsesRt(idUsesRt), .idBranch(idBranch), .idTaken(idTaken),
    .idRegWrite(idRegWrite), .idMemRead(idMemRead), .idDest(idDest),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
    .nopOut(nopOut), .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  hazard_unit #(.REG_W(5), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs),
    .idUsesRt(idUsesRt), .idBranch(idBranch), .idTaken(idTaken),
    .idRegWrite(idRegWrite), .idMemRead(idMemRead), .idDest(idDest),
    .pcWrite(s_pcWrite), .ifidWrite(s_ifidWrite), .ifidFlush(s_ifidFlush),
    .nopOut(s_nopOut), .stallCnt(s_stallCnt), .flushCnt(s_flushCnt)
  );

  task automatic set_id(input int rs, input bit urs, input int rt, input bit urt,
                        input bit br, input bit tk, input bit rw, input bit mr,
                        input int dest);
    idRs = 5'(rs); idUsesRs = urs; idRt = 5'(rt); idUsesRt = urt;
    idBranch = br; idTaken = tk; idRegWrite = rw; idMemRead = mr;
    idDest = 5'(dest);
  endtask

  task automatic set_idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_clear();
    m_ex = '0; m_mem = '0;
    m_sc = 16'd0; m_fc = 16'd0; m_sc4 = 4'd0; m_fc4 = 4'd0;
  endtask

  function automatic bit depends(input ent_t e, input logic [4:0] r, input bit uses);
    return uses && (r != 5'd0) && e.valid && (e.dest == r);
  endfunction

  // Hazard rules: a consumer waits on a load one instruction ahead; a branch
  // waits on any write one ahead or a load two ahead.
  function automatic bit model_stall();
    bit d_ex, d_mem;
    d_ex  = depends(m_ex, idRs, idUsesRs) || depends(m_ex, idRt, idUsesRt);
    d_mem = depends(m_mem, idRs, idUsesRs) || depends(m_mem, idRt, idUsesRt);
    return (m_ex.mr && d_ex) || (idBranch && ((m_ex.rw && d_ex) || (m_mem.mr && d_mem)));
  endfunction

  // Advance one clock (negedge to negedge), moving the model in step.
  task automatic tick();
    bit s;
    s = model_stall();
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (s && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (s && m_sc4 != 4'hF) m_sc4 = m_sc4 + 4'd1;
      if (idTaken && !s && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      if (idTaken && !s && m_fc4 != 4'hF) m_fc4 = m_fc4 + 4'd1;
      m_mem = m_ex;
      m_ex = s ? ent_t'('0) : '{valid: 1'b1, dest: idDest, rw: idRegWrite, mr: idMemRead};
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    model_clear();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_id(1, 1, 2, 1, 1, 1, 1, 1, 3);
    model_clear();
    #1;
    checks++;
    if ({pcWrite, ifidWrite, nopOut, ifidFlush} !== 4'b0010) begin
      errors++; $display("FAIL reset_outputs got %b expected 0010", {pcWrite, ifidWrite, nopOut, ifidFlush});
    end
    tick();
    checks++;
    if ({stallCnt, flushCnt} !== 32'd0) begin
      errors++; $display("FAIL reset_counters got %h expected 00000000", {stallCnt, flushCnt});
    end
    set_idle();
    rst = 1'b0;
    #1;
    checks++;
    if ({pcWrite, ifidWrite, nopOut, ifidFlush} !== 4'b1100) begin
      errors++; $display("FAIL after_reset got %b expected 1100", {pcWrite, ifidWrite, nopOut, ifidFlush});
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(0, 0, 0, 0, 0, 0, 1, 1, 2);        // lw $2
    tick();
    set_id(2, 1, 3, 1, 0, 0, 1, 0, 4);        // add $4,$2,$3
    #1;
    checks++;
    if ({pcWrite, nopOut} !== 2'b01) begin
      errors++; $display("FAIL load_use_stall got %b expected 01", {pcWrite, nopOut});
    end
    tick();
    #1;
    checks++;
    if ({pcWrite, nopOut} !== 2'b10) begin
      errors++; $display("FAIL load_use_release got %b expected 10", {pcWrite, nopOut});
    end
    tick();
    checks++;
    if (stallCnt !== 16'd1) begin
      errors++; $display("FAIL load_use_count got %0d expected 1", stallCnt);
    end
  endtask

  task automatic test_lw_beq();
    do_reset();
    set_id(0, 0, 0, 0, 0, 0, 1, 1, 5);        // lw $5
    tick();
    set_id(5, 1, 6, 1, 1, 0, 0, 0, 0);        // beq $5,$6
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (nopOut !== 1'b1) begin
        errors++; $display("FAIL lw_beq_stall%0d got %b expected 1", i, nopOut);
      end
      tick();
    end
    idTaken = 1'b1;
    #1;
    checks++;
    if ({pcWrite, nopOut, ifidFlush} !== 3'b101) begin
      errors++; $display("FAIL lw_beq_taken got %b expected 101", {pcWrite, nopOut, ifidFlush});
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (ifidFlush !== 1'b0) begin
      errors++; $display("FAIL lw_beq_flush_drop got %b expected 0", ifidFlush);
    end
    tick();
    checks++;
    if ({stallCnt, flushCnt} !== {16'd2, 16'd1}) begin
      errors++; $display("FAIL lw_beq_counts got %0d/%0d expected 2/1", stallCnt, flushCnt);
    end
  endtask

  task automatic test_alu_beq();
    do_reset();
    set_id(1, 1, 2, 1, 0, 0, 1, 0, 9);        // add $9
    tick();
    set_id(9, 1, 0, 1, 1, 0, 0, 0, 0);        // beq $9,$0
    #1;
    checks++;
    if (nopOut !== 1'b1) begin
      errors++; $display("FAIL alu_beq_stall got %b expected 1", nopOut);
    end
    tick();
    #1;
    checks++;
    if (nopOut !== 1'b0) begin
      errors++; $display("FAIL alu_beq_release got %b expected 0", nopOut);
    end
    tick();
  endtask

  task automatic test_reg0_and_nonreading();
    do_reset();
    set_id(1, 1, 2, 1, 0, 0, 1, 1, 0);        // lw $0
    tick();
    set_id(0, 1, 0, 1, 1, 0, 0, 0, 0);        // beq $0,$0
    #1;
    checks++;
    if (nopOut !== 1'b0) begin
      errors++; $display("FAIL reg0_stall got %b expected 0", nopOut);
    end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 1, 1, 3);        // lw $3
    tick();
    set_id(1, 1, 3, 0, 0, 0, 0, 0, 0);        // sw with rt = 3 not read
    #1;
    checks++;
    if (nopOut !== 1'b0) begin
      errors++; $display("FAIL nonreading_stall got %b expected 0", nopOut);
    end
    tick();
    checks++;
    if (stallCnt !== 16'd0) begin
      errors++; $display("FAIL no_stall_count got %0d expected 0", stallCnt);
    end
  endtask

  task automatic test_priority();
    do_reset();
    set_id(0, 0, 0, 0, 0, 0, 1, 1, 7);        // lw $7
    tick();
    set_id(7, 1, 0, 0, 1, 1, 0, 0, 0);        // beq $7 with taken asserted
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({nopOut, ifidFlush} !== 2'b10) begin
        errors++; $display("FAIL priority%0d got %b expected 10", i, {nopOut, ifidFlush});
      end
      tick();
    end
    #1;
    checks++;
    if ({nopOut, ifidFlush} !== 2'b01) begin
      errors++; $display("FAIL priority_resolve got %b expected 01", {nopOut, ifidFlush});
    end
    tick();
    set_idle();
    tick();
    checks++;
    if (flushCnt !== 16'd1) begin
      errors++; $display("FAIL priority_flushcnt got %0d expected 1", flushCnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(0, 0, 0, 0, 0, 0, 1, 1, 4);        // lw $4
    tick();
    set_id(4, 1, 0, 0, 0, 0, 1, 0, 8);        // add reading $4
    tick();                                   // counted stall
    set_id(0, 0, 0, 0, 0, 0, 1, 1, 4);        // lw $4 again
    tick();
    set_id(4, 1, 0, 0, 0, 0, 1, 0, 8);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if ({pcWrite, nopOut, stallCnt} !== {1'b0, 1'b1, 16'd0}) begin
      errors++; $display("FAIL reset_mid_stall got pc=%b nop=%b cnt=%0d expected 0/1/0", pcWrite, nopOut, stallCnt);
    end
    @(negedge clk);
    set_idle();
    rst = 1'b0;
    #1;
    checks++;
    if ({pcWrite, nopOut} !== 2'b10) begin
      errors++; $display("FAIL after_mid_reset got %b expected 10", {pcWrite, nopOut});
    end
    tick();
  endtask

  // The narrow-counter instance shows the saturation behaviour quickly.
  task automatic test_saturation();
    do_reset();
    for (int r = 0; r < 9; r++) begin
      set_id(0, 0, 0, 0, 0, 0, 1, 1, 5);
      tick();
      set_id(5, 1, 0, 0, 1, 0, 0, 0, 0);
      tick();
      tick();
      if (r == 6) begin
        checks++;
        if (s_stallCnt !== 4'd14) begin
          errors++; $display("FAIL sat_below got %0d expected 14", s_stallCnt);
        end
      end
    end
    checks++;
    if ({s_stallCnt, stallCnt} !== {4'hF, 16'd18}) begin
      errors++; $display("FAIL saturation got %0d/%0d expected 15/18", s_stallCnt, stallCnt);
    end
  endtask

  task automatic test_random();
    bit s;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_id($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
      if (rst) model_clear();
      s = model_stall();
      #1;
      checks++;
      if ({pcWrite, ifidWrite, nopOut, ifidFlush, s_pcWrite, s_nopOut} !==
          (rst ? 6'b001001 : {!s, !s, s, idTaken && !s, !s, s})) begin
        errors++; $display("FAIL random_outputs cycle %0d got %b expected stall=%b rst=%b", i,
                           {pcWrite, ifidWrite, nopOut, ifidFlush, s_pcWrite, s_nopOut}, s, rst);
      end
      tick();
      checks++;
      if ({stallCnt, flushCnt, s_stallCnt, s_flushCnt} !== {m_sc, m_fc, m_sc4, m_fc4}) begin
        errors++; $display("FAIL random_counters cycle %0d got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                           i, stallCnt, flushCnt, s_stallCnt, s_flushCnt, m_sc, m_fc, m_sc4, m_fc4);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    model_clear();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_lw_beq();
    test_alu_beq();
    test_reg0_and_nonreading();
    test_priority();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
